// File: rtl/complex_sqrt_seq_if.sv
// Operand/result handshake bundle for the sequential complex square root.
// The producer side drives operands and out_ready; the root block drives the remaining signals.
interface complex_sqrt_seq_if #(
    parameter int WIDTH = 8
);
    logic signed [2*WIDTH-1:0] inReal;
    logic signed [2*WIDTH-1:0] inImag;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH:0]     outReal;
    logic signed [WIDTH:0]     outImag;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output inReal, inImag, in_valid, out_ready,
        input  in_ready, outReal, outImag, out_valid
    );

    modport slave (
        input  inReal, inImag, in_valid, out_ready,
        output in_ready, outReal, outImag, out_valid
    );
endinterface

// File: rtl/complex_sqrt_seq.sv
// Principal complex square root w = u + jv of z = x + jy using floor integer roots.
// One digit-pair root engine is reused for M = |z|, U = sqrt((M+x)/2) and V = sqrt((M-x)/2).
module complex_sqrt_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    complex_sqrt_seq_if.slave   bus,
    output logic                busy
);
    localparam int W2 = 2 * WIDTH;
    localparam int W4 = 4 * WIDTH;
    localparam int RW = W2 + 3;
    localparam int CW = $clog2(W2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SUMSQ,
        ROOT_M,
        ROOT_U,
        ROOT_V,
        DONE
    } state_t;

    state_t stateReg, stateNext;

    logic signed [W2-1:0]   xReg, yReg;
    logic [W4-1:0]          radReg;
    logic [RW-1:0]          remReg;
    logic [W2-1:0]          rootReg;
    logic [W2-1:0]          mReg;
    logic [WIDTH-1:0]       uReg;
    logic [CW-1:0]          cntReg;
    logic signed [WIDTH:0]  outRealReg, outImagReg;

    logic signed [W4-1:0]   sqX, sqY;
    logic [W4-1:0]          sumSq;
    logic [RW-1:0]          remShift, trial, remStep;
    logic [W2-1:0]          rootStep;
    logic                   fits;
    logic                   lastStep;
    logic [W2:0]            mPlusX, mMinusX;
    logic [W2-1:0]          radU, radV;
    logic [WIDTH:0]         vExt;

    // Squares are formed in the full 4W-bit signed width so -2^(2W-1) squared stays exact.
    assign sqX   = W4'(xReg) * W4'(xReg);
    assign sqY   = W4'(yReg) * W4'(yReg);
    assign sumSq = $unsigned(sqX) + $unsigned(sqY);

    // One restoring iteration: bring down two radicand bits, try (2*root)*2+1.
    assign remShift = RW'({remReg, radReg[W4-1:W4-2]});
    assign trial    = {1'b0, rootReg, 2'b01};
    assign fits     = (remShift >= trial);
    assign remStep  = fits ? (remShift - trial) : remShift;
    assign rootStep = {rootReg[W2-2:0], fits};

    assign lastStep = ((stateReg == ROOT_M) && (cntReg == CW'(W2 - 1))) ||
                      (((stateReg == ROOT_U) || (stateReg == ROOT_V)) && (cntReg == CW'(WIDTH - 1)));

    // M >= |x|, so both sums are non-negative and the halves fit in 2W bits.
    assign mPlusX  = {1'b0, rootStep} + {xReg[W2-1], xReg};
    assign mMinusX = {1'b0, mReg} - {xReg[W2-1], xReg};
    assign radU    = W2'(mPlusX >> 1);
    assign radV    = W2'(mMinusX >> 1);
    assign vExt    = {1'b0, rootStep[WIDTH-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (stateReg)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) stateNext = SUMSQ;
            end
            SUMSQ:  stateNext = ROOT_M;
            ROOT_M: if (lastStep) stateNext = ROOT_U;
            ROOT_U: if (lastStep) stateNext = ROOT_V;
            ROOT_V: if (lastStep) stateNext = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xReg       <= '0;
            yReg       <= '0;
            radReg     <= '0;
            remReg     <= '0;
            rootReg    <= '0;
            mReg       <= '0;
            uReg       <= '0;
            cntReg     <= '0;
            outRealReg <= '0;
            outImagReg <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.in_valid) begin
                        xReg <= bus.inReal;
                        yReg <= bus.inImag;
                    end
                end
                SUMSQ: begin
                    radReg  <= sumSq;
                    remReg  <= '0;
                    rootReg <= '0;
                    cntReg  <= '0;
                end
                ROOT_M, ROOT_U, ROOT_V: begin
                    if (lastStep) begin
                        remReg  <= '0;
                        rootReg <= '0;
                        cntReg  <= '0;
                        // Next radicand is left-aligned so the engine always consumes from the top.
                        if (stateReg == ROOT_M) begin
                            mReg   <= rootStep;
                            radReg <= {radU, {W2{1'b0}}};
                        end else if (stateReg == ROOT_U) begin
                            uReg   <= rootStep[WIDTH-1:0];
                            radReg <= {radV, {W2{1'b0}}};
                        end else begin
                            outRealReg <= {1'b0, uReg};
                            outImagReg <= yReg[W2-1] ? -vExt : vExt;
                        end
                    end else begin
                        remReg  <= remStep;
                        rootReg <= rootStep;
                        radReg  <= radReg << 2;
                        cntReg  <= cntReg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.outReal = outRealReg;
    assign bus.outImag = outImagReg;
endmodule
